// File: rtl/adder_in_packer_pkg.sv
// adder_in_packer_pkg: shared operand layout and packer state encoding
package adder_in_packer_pkg;

    localparam int INS_W = 33;

    typedef struct packed {
        logic [7:0] w;
        logic [7:0] z;
        logic [7:0] y;
        logic [7:0] x;
    } s1_t;

    typedef struct packed {
        logic cin;
        s1_t  s1;
    } ins_t;

    typedef enum logic [2:0] {SX, SY, SZ, SW, RESYNC} state_t;

endpackage

// File: rtl/adder_in_packer_idle_timer.sv
// packer_idle_timer: counts idle cycles inside a frame and flags expiry
module packer_idle_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int W = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

    logic [W-1:0] cnt;

    // expiry fires on the idle cycle that would bring the count up to TIMEOUT
    assign expire = (TIMEOUT != 0) && enable && !clear && (cnt == LAST);

    // idle counter: cleared on demand, restarts after expiry, frozen when disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clear || TIMEOUT == 0)
            cnt <= '0;
        else if (enable)
            cnt <= expire ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/adder_in_packer.sv
// adder_in_packer: assembles 4-byte frames into packed adder operand words
module adder_in_packer
    import adder_in_packer_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic             in_cin,
    output logic [INS_W-1:0] ins,
    output logic             ins_valid,
    input  logic             ins_ready,
    output logic             frame_err,
    output logic             timeout_err,
    output logic [CNT_W-1:0] word_cnt
);

    state_t state;
    s1_t    frame_r;
    logic   cin_r;
    ins_t   ins_r;
    logic   accept;
    logic   busy;
    logic   expire;

    // only the final byte can be refused, and only while the previous word is stuck
    assign in_ready = !(state == SW && ins_valid && !ins_ready);
    assign accept   = in_valid && in_ready;
    assign busy     = (state == SY) || (state == SZ) || (state == SW);
    assign ins      = ins_r;

    packer_idle_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (accept || !busy),
        .enable (busy && in_ready && !accept),
        .expire (expire)
    );

    // frame assembly FSM with registered word, error pulses and counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SX;
            frame_r     <= '0;
            cin_r       <= 1'b0;
            ins_r       <= '0;
            ins_valid   <= 1'b0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
            word_cnt    <= '0;
        end else begin
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
            if (ins_valid && ins_ready)
                ins_valid <= 1'b0;
            if (accept) begin
                case (state)
                    SX: begin
                        frame_r.x <= in_data;
                        cin_r     <= in_cin;
                        frame_err <= in_last;
                        state     <= in_last ? SX : SY;
                    end
                    SY: begin
                        frame_r.y <= in_data;
                        frame_err <= in_last;
                        state     <= in_last ? SX : SZ;
                    end
                    SZ: begin
                        frame_r.z <= in_data;
                        frame_err <= in_last;
                        state     <= in_last ? SX : SW;
                    end
                    SW: begin
                        if (in_last) begin
                            ins_r     <= '{cin: cin_r, s1: '{w: in_data, z: frame_r.z, y: frame_r.y, x: frame_r.x}};
                            ins_valid <= 1'b1;
                            word_cnt  <= word_cnt + 1'b1;
                            state     <= SX;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= RESYNC;
                        end
                    end
                    default: state <= in_last ? SX : RESYNC;
                endcase
            end else if (expire) begin
                timeout_err <= 1'b1;
                state       <= SX;
            end
        end
    end

endmodule

// File: doc/adder_in_packer.md
Name: adder_in_packer

Overview:
- Upstream feeder for the 4-operand byte adder.
- Accepts a byte stream over a valid/ready handshake, with a per-frame carry-in sideband.
- Assembles each 4-byte frame into the 33-bit packed operand word {cin, w, z, y, x} and presents it with a valid/ready output.
- Detects frame-length errors and inter-byte timeouts, and discards partial frames cleanly.

Parameters:
- TIMEOUT, 16, idle cycles allowed between bytes of one frame before the partial frame is dropped; 0 disables the timeout.
- CNT_W, 16, width of the emitted-word counter.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- in_data  input  8  stream byte
- in_valid  input  1  byte valid
- in_ready  output  1  byte accepted when in_valid && in_ready
- in_last  input  1  marks final byte of a frame
- in_cin  input  1  carry-in; sampled only with the first (x) byte
- ins  output  33  packed word: x[7:0], y[15:8], z[23:16], w[31:24], cin[32]
- ins_valid  output  1  ins holds an unconsumed word
- ins_ready  input  1  downstream takes the word
- frame_err  output  1  one-cycle pulse on bad frame length
- timeout_err  output  1  one-cycle pulse on inter-byte timeout
- word_cnt  output  CNT_W  count of words emitted, wraps modulo 2^CNT_W

Behaviour:
- Reset values:
  - state=SX; ins=0; ins_valid=0; frame_err=0; timeout_err=0; word_cnt=0; idle counter=0.
  - in_ready=1 after reset.
- States:
  - SX, SY, SZ, SW: expecting byte x, y, z, w respectively.
  - RESYNC: dropping bytes until a frame boundary.
- Byte acceptance:
  - A byte is accepted on a clock edge where in_valid && in_ready.
  - Accepting in SX, SY or SZ writes the byte into the assembly register slot and advances SX->SY->SZ->SW.
  - In SX, in_cin is also captured.
- in_ready:
  - in_ready = !(state==SW && ins_valid && !ins_ready).
  - This is combinational from ins_ready and state.
  - In all other states in_ready=1.
- Completion:
  - Accepting a byte in SW with in_last=1 loads ins with {cin, in_data, z, y, x} on that edge.
  - ins_valid=1 from the next cycle; latency is 1 cycle from acceptance of w.
  - word_cnt increments on the same edge; state goes to SX.
- Output hold:
  - ins and ins_valid stay stable while ins_valid && !ins_ready.
  - ins_valid clears on ins_valid && ins_ready, unless a new word loads on the same edge; in that case ins_valid stays 1 and ins takes the new word.
- Early last:
  - in_last=1 on an accepted byte in SX, SY or SZ discards the partial frame.
  - frame_err pulses for 1 cycle; state goes to SX.
- Missing last:
  - in_last=0 on the accepted byte in SW discards the frame; no load, no count.
  - frame_err pulses; state goes to RESYNC.
- RESYNC:
  - Accepts and drops bytes.
  - An accepted byte with in_last=1 returns the state to SX; no further error pulse.
- Timeout:
  - In SY, SZ or SW, the idle counter increments on each cycle with no accepted byte and clears on acceptance.
  - Cycles where in_ready=0 (output stall) do not count.
  - When the counter reaches TIMEOUT, the partial frame is discarded, timeout_err pulses, state goes to SX and the counter clears.
  - The counter is held at 0 in SX and RESYNC and when TIMEOUT=0.
- Simultaneous events:
  - An error in the same cycle as an output handshake: the handshake still completes normally.
  - Timeout and an acceptance in the same cycle: the acceptance wins and the counter clears.
- Reset mid-frame: the partial frame and any pending ins word are lost; no error pulse is generated.
- Width rule: word_cnt wraps from 2^CNT_W-1 to 0 with no flag.

Decomposition:
- Shared package:
  - s1_t struct {x, y, z, w} of 8 bits each.
  - ins_t struct {s1_t s1; cin} totalling 33 bits.
  - Constant INS_W=33.
  - State enum for SX, SY, SZ, SW, RESYNC.
  - This package is also used by the downstream adder.
- Sub-module: one natural sub-module, packer_idle_timer, holding the TIMEOUT counter with clear/enable/expire signals.

Test Plan:
- Bytes 0x11,0x22,0x33,0x44 with last on 0x44, cin=1, ins_ready=1 -> ins=0x1_44332211, ins_valid high for one cycle, word_cnt=1.
- Two back-to-back frames with ins_ready=0 until 5 cycles after the second w is offered:
  - in_ready drops while w2 is presented; ins holds word1.
  - After the ins_ready handshake, word2 loads; no byte is lost.
- in_last on the second byte (0xAA,0xBB) -> frame_err pulse one cycle; next frame 0x01..0x04 emits ins=0x0_04030201.
- Five-byte frame with last on byte 5 -> frame_err on byte 4, RESYNC drops byte 5, no ins_valid; the following good frame emits correctly.
- TIMEOUT=16: x and y accepted, then 16 idle cycles -> timeout_err pulse at cycle 16, no ins_valid; the next frame decodes normally.
- Assert rst_n=0 after byte z, then release -> all outputs 0, in_ready=1; the next full frame emits and word_cnt=1.
